bbox_pixel_scanner: RTL and testbench

//   Upstream feeder of the edge-function stage. Accepts one triangle (3 signed vertices), computes its

---
 rtl/bbox_pixel_scanner_if.sv | 35 +++
 rtl/bbox_pixel_scanner.sv | 165 ++++++++++++++++
 tb/tb_bbox_pixel_scanner.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bbox_pixel_scanner_if.sv
// bbox_pixel_scanner_if
//   Groups the triangle-in and pixel-out handshakes of bbox_pixel_scanner.
//   master : upstream feeder / downstream consumer side (drives tri_valid, vertices, pix_ready)
//   slave  : the scanner itself (drives tri_ready, pix_valid, pixel_x, pixel_y, pix_last)
//   Signals:
//     tri_valid, tri_ready          triangle handshake
//     v0_x..v2_y  [10:0] signed     triangle vertices
//     pix_valid, pix_ready          pixel handshake
//     pixel_x, pixel_y [10:0]       pixel coordinate
//     pix_last                      final pixel of the current triangle
interface bbox_pixel_scanner_if;
   logic               tri_valid;
   logic               tri_ready;
   logic signed [10:0] v0_x;
   logic signed [10:0] v0_y;
   logic signed [10:0] v1_x;
   logic signed [10:0] v1_y;
   logic signed [10:0] v2_x;
   logic signed [10:0] v2_y;
   logic               pix_valid;
   logic               pix_ready;
   logic        [10:0] pixel_x;
   logic        [10:0] pixel_y;
   logic               pix_last;

   modport master (
      output tri_valid, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y, pix_ready,
      input  tri_ready, pix_valid, pixel_x, pixel_y, pix_last
   );

   modport slave (
      input  tri_valid, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y, pix_ready,
      output tri_ready, pix_valid, pixel_x, pixel_y, pix_last
   );
endinterface

// File: rtl/bbox_pixel_scanner.sv
// bbox_pixel_scanner
//   Accepts one triangle, computes its screen-clamped bounding box and streams
//   every pixel of the box in raster order (x fastest) on a valid/ready stream.
//   Ports:
//     clk       clock
//     reset     synchronous, active-high
//     bus       bbox_pixel_scanner_if.slave (triangle in, pixel stream out)
//     busy      high from triangle acceptance until the done cycle completes
//     tri_done  one-cycle pulse when a triangle is finished (also for empty box)
//     pix_count [21:0] accepted pixels of the current triangle (BBOX_PIXCOUNT_EN only)
//   Optional feature macro: BBOX_PIXCOUNT_EN
module bbox_pixel_scanner #(
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480
) (
   input  logic                clk,
   input  logic                reset,
   bbox_pixel_scanner_if.slave bus,
   output logic                busy,
   output logic                tri_done
`ifdef BBOX_PIXCOUNT_EN
   ,
   output logic [21:0]         pix_count
`endif
);

   // 12-bit signed limits: screen sizes up to 2047 do not fit an 11-bit signed compare
   localparam logic signed [11:0] X_LIM = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] Y_LIM = 12'(SCREEN_H - 1);

   typedef enum logic [1:0] {IDLE, BBOX, SCAN, DONE} state_t;

   state_t             state;
   logic signed [10:0] vx [3];
   logic signed [10:0] vy [3];
   logic               tri_ready_q;
   logic               pix_valid_q;
   logic        [10:0] x, y;
   logic        [10:0] min_x, max_x, max_y;

   logic signed [11:0] lo_x, hi_x, lo_y, hi_y;
   logic        [10:0] clo_x, chi_x, clo_y, chi_y;
   logic               empty;
   logic               at_last;
   logic               pix_hs;

   function automatic logic signed [11:0] min3(input logic signed [10:0] a, b, c);
      logic signed [10:0] m;
      m = (a < b) ? a : b;
      m = (c < m) ? c : m;
      return {m[10], m};
   endfunction

   function automatic logic signed [11:0] max3(input logic signed [10:0] a, b, c);
      logic signed [10:0] m;
      m = (a > b) ? a : b;
      m = (c > m) ? c : m;
      return {m[10], m};
   endfunction

   always_comb begin
      lo_x  = min3(vx[0], vx[1], vx[2]);
      hi_x  = max3(vx[0], vx[1], vx[2]);
      lo_y  = min3(vy[0], vy[1], vy[2]);
      hi_y  = max3(vy[0], vy[1], vy[2]);
      // emptiness is judged on the raw extents, before clamping
      empty = hi_x[11] || hi_y[11] || (lo_x > X_LIM) || (lo_y > Y_LIM);
      clo_x = lo_x[11] ? '0 : lo_x[10:0];
      clo_y = lo_y[11] ? '0 : lo_y[10:0];
      chi_x = (hi_x > X_LIM) ? X_LIM[10:0] : hi_x[10:0];
      chi_y = (hi_y > Y_LIM) ? Y_LIM[10:0] : hi_y[10:0];
   end

   assign at_last       = (x == max_x) && (y == max_y);
   assign pix_hs        = pix_valid_q && bus.pix_ready;
   assign bus.tri_ready = tri_ready_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pixel_x   = x;
   assign bus.pixel_y   = y;
   // gated so stale coordinate registers never flag a last pixel outside SCAN
   assign bus.pix_last  = pix_valid_q && at_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         tri_ready_q <= 1'b1;
         pix_valid_q <= 1'b0;
         busy        <= 1'b0;
         tri_done    <= 1'b0;
         x           <= '0;
         y           <= '0;
         min_x       <= '0;
         max_x       <= '0;
         max_y       <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            vx[i] <= '0;
            vy[i] <= '0;
         end
      end else begin
         tri_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.tri_valid) begin
                  vx[0]       <= bus.v0_x;
                  vy[0]       <= bus.v0_y;
                  vx[1]       <= bus.v1_x;
                  vy[1]       <= bus.v1_y;
                  vx[2]       <= bus.v2_x;
                  vy[2]       <= bus.v2_y;
                  tri_ready_q <= 1'b0;
                  busy        <= 1'b1;
                  state       <= BBOX;
               end
            end
            BBOX: begin
               if (empty) begin
                  tri_done <= 1'b1;
                  state    <= DONE;
               end else begin
                  min_x       <= clo_x;
                  max_x       <= chi_x;
                  max_y       <= chi_y;
                  x           <= clo_x;
                  y           <= clo_y;
                  pix_valid_q <= 1'b1;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               if (pix_hs) begin
                  if (at_last) begin
                     pix_valid_q <= 1'b0;
                     tri_done    <= 1'b1;
                     state       <= DONE;
                  end else if (x < max_x) begin
                     x <= x + 11'd1;
                  end else begin
                     x <= min_x;
                     y <= y + 11'd1;
                  end
               end
            end
            DONE: begin
               tri_ready_q <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BBOX_PIXCOUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_count <= '0;
      end else if (state == IDLE && bus.tri_valid) begin
         pix_count <= '0;
      end else if (state == SCAN && pix_hs) begin
         pix_count <= pix_count + 22'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bbox_pixel_scanner.sv
// tb_bbox_pixel_scanner
//   Bench for bbox_pixel_scanner: one 640x480 instance and one 16x8 instance
//   share the stimulus signals; 'sel' routes the triangle handshake to one of them
//   and selects which one's outputs are observed.
module tb_bbox_pixel_scanner;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sel = 1'b0;
   logic tri_valid = 1'b0;
   logic pix_ready = 1'b0;
   logic signed [10:0] v0_x = '0, v0_y = '0, v1_x = '0, v1_y = '0, v2_x = '0, v2_y = '0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bbox_pixel_scanner_if ifa ();
   bbox_pixel_scanner_if ifb ();

   assign ifa.tri_valid = tri_valid & ~sel;
   assign ifb.tri_valid = tri_valid & sel;
   assign ifa.pix_ready = pix_ready;
   assign ifb.pix_ready = pix_ready;
   assign ifa.v0_x = v0_x;  assign ifb.v0_x = v0_x;
   assign ifa.v0_y = v0_y;  assign ifb.v0_y = v0_y;
   assign ifa.v1_x = v1_x;  assign ifb.v1_x = v1_x;
   assign ifa.v1_y = v1_y;  assign ifb.v1_y = v1_y;
   assign ifa.v2_x = v2_x;  assign ifb.v2_x = v2_x;
   assign ifa.v2_y = v2_y;  assign ifb.v2_y = v2_y;

   logic busy_a, busy_b, done_a, done_b;
`ifdef BBOX_PIXCOUNT_EN
   logic [21:0] cnt_a, cnt_b, o_pix_count;
`endif

   bbox_pixel_scanner #(.SCREEN_W(640), .SCREEN_H(480)) dut (
      .clk(clk), .reset(reset), .bus(ifa), .busy(busy_a), .tri_done(done_a)
`ifdef BBOX_PIXCOUNT_EN
      , .pix_count(cnt_a)
`endif
   );

   bbox_pixel_scanner #(.SCREEN_W(16), .SCREEN_H(8)) dut_small (
      .clk(clk), .reset(reset), .bus(ifb), .busy(busy_b), .tri_done(done_b)
`ifdef BBOX_PIXCOUNT_EN
      , .pix_count(cnt_b)
`endif
   );

   logic o_tri_ready, o_pix_valid, o_pix_last, o_busy, o_tri_done;
   logic [10:0] o_x, o_y;
   assign o_tri_ready = sel ? ifb.tri_ready : ifa.tri_ready;
   assign o_pix_valid = sel ? ifb.pix_valid : ifa.pix_valid;
   assign o_pix_last  = sel ? ifb.pix_last  : ifa.pix_last;
   assign o_x         = sel ? ifb.pixel_x   : ifa.pixel_x;
   assign o_y         = sel ? ifb.pixel_y   : ifa.pixel_y;
   assign o_busy      = sel ? busy_b : busy_a;
   assign o_tri_done  = sel ? done_b : done_a;
`ifdef BBOX_PIXCOUNT_EN
   assign o_pix_count = sel ? cnt_b : cnt_a;
`endif

   // Drives one triangle and checks the whole transaction against a list of
   // pixels derived from the bounding-box rules. abort_at >= 0 asserts reset
   // while that pixel index is being offered.
   task automatic run_tri(input logic s, input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input int rdy_pct, input int abort_at);
      int ex[$];
      int ey[$];
      int w, h, lx, hx, ly, hy, n, idx, t, last_hs, limit;
      bit stalled, seen, finished;
      logic [10:0] px, py;
      logic pl, want_last;
      w = s ? 16 : 640;
      h = s ? 8 : 480;
      lx = ax; if (bx < lx) lx = bx; if (cx < lx) lx = cx;
      hx = ax; if (bx > hx) hx = bx; if (cx > hx) hx = cx;
      ly = ay; if (by < ly) ly = by; if (cy < ly) ly = cy;
      hy = ay; if (by > hy) hy = by; if (cy > hy) hy = cy;
      if (!(hx < 0 || hy < 0 || lx > w - 1 || ly > h - 1)) begin
         if (lx < 0) lx = 0;
         if (ly < 0) ly = 0;
         if (hx > w - 1) hx = w - 1;
         if (hy > h - 1) hy = h - 1;
         for (int yy = ly; yy <= hy; yy++)
            for (int xx = lx; xx <= hx; xx++) begin
               ex.push_back(xx);
               ey.push_back(yy);
            end
      end
      n = ex.size();

      @(negedge clk);
      sel = s;
      pix_ready = 1'b0;
      @(negedge clk);
      limit = 0;
      while (o_tri_ready !== 1'b1 && limit < 20) begin
         @(negedge clk);
         limit++;
      end
      total++;
      if (o_tri_ready !== 1'b1) begin
         bad++;
         $display("FAIL tri_ready_wait got=%b exp=1", o_tri_ready);
         return;
      end
      tri_valid = 1'b1;
      v0_x = 11'(ax); v0_y = 11'(ay);
      v1_x = 11'(bx); v1_y = 11'(by);
      v2_x = 11'(cx); v2_y = 11'(cy);
      @(negedge clk);
      // handshake happened at the posedge just passed; scramble vertices to prove they are ignored
      tri_valid = 1'b0;
      v0_x = 11'($urandom); v0_y = 11'($urandom);
      v1_x = 11'($urandom); v1_y = 11'($urandom);
      v2_x = 11'($urandom); v2_y = 11'($urandom);
      t = 1;
      total++;
      if (o_pix_valid !== 1'b0 || o_busy !== 1'b1 || o_tri_ready !== 1'b0 || o_tri_done !== 1'b0) begin
         bad++;
         $display("FAIL bbox_cycle got valid=%b busy=%b ready=%b done=%b exp 0 1 0 0",
                  o_pix_valid, o_busy, o_tri_ready, o_tri_done);
      end

      idx = 0; last_hs = 0; stalled = 0; seen = 0; finished = 0;
      px = '0; py = '0; pl = 1'b0;
      limit = 8 * n + 20;
      while (!finished && t < limit) begin
         @(negedge clk);
         t++;
         if (abort_at >= 0 && idx == abort_at && o_pix_valid === 1'b1) begin
            reset = 1'b1;
            pix_ready = 1'b0;
            @(negedge clk);
            total++;
            if (o_pix_valid !== 1'b0 || o_busy !== 1'b0 || o_tri_done !== 1'b0 || o_pix_last !== 1'b0) begin
               bad++;
               $display("FAIL abort_state got valid=%b busy=%b done=%b last=%b exp all 0",
                        o_pix_valid, o_busy, o_tri_done, o_pix_last);
            end
            reset = 1'b0;
            repeat (6) begin
               @(negedge clk);
               total++;
               if (o_tri_done !== 1'b0 || o_pix_valid !== 1'b0) begin
                  bad++;
                  $display("FAIL abort_quiet got done=%b valid=%b exp 0 0", o_tri_done, o_pix_valid);
               end
            end
            total++;
            if (o_tri_ready !== 1'b1) begin
               bad++;
               $display("FAIL abort_ready got=%b exp=1", o_tri_ready);
            end
            return;
         end
         pix_ready = (int'($urandom_range(99)) < rdy_pct);
`ifdef BBOX_PIXCOUNT_EN
         total++;
         if (o_pix_count !== 22'(idx)) begin
            bad++;
            $display("FAIL pix_count got=%0d exp=%0d", o_pix_count, idx);
         end
`endif
         if (o_tri_done === 1'b1) begin
            finished = 1;
            total++;
            if (idx != n) begin
               bad++;
               $display("FAIL pixel_total got=%0d exp=%0d", idx, n);
            end
            total++;
            if (t != ((n == 0) ? 2 : last_hs + 1)) begin
               bad++;
               $display("FAIL done_timing got=%0d exp=%0d", t, (n == 0) ? 2 : last_hs + 1);
            end
            total++;
            if (o_pix_valid !== 1'b0) begin
               bad++;
               $display("FAIL done_valid got=%b exp=0", o_pix_valid);
            end
         end else if (o_pix_valid === 1'b1) begin
            total++;
            if (o_busy !== 1'b1 || o_tri_ready !== 1'b0) begin
               bad++;
               $display("FAIL busy_flags got busy=%b ready=%b exp 1 0", o_busy, o_tri_ready);
            end
            if (!seen) begin
               seen = 1;
               total++;
               if (t != 2) begin
                  bad++;
                  $display("FAIL first_latency got=%0d exp=2", t);
               end
            end
            total++;
            if (idx >= n) begin
               bad++;
               $display("FAIL extra_pixel got x=%0d y=%0d exp none", o_x, o_y);
            end else begin
               want_last = (idx == n - 1) ? 1'b1 : 1'b0;
               if (o_x !== 11'(ex[idx]) || o_y !== 11'(ey[idx]) || o_pix_last !== want_last) begin
                  bad++;
                  $display("FAIL pixel[%0d] got (%0d,%0d,last=%b) exp (%0d,%0d,last=%b)",
                           idx, o_x, o_y, o_pix_last, ex[idx], ey[idx], want_last);
               end
            end
            if (stalled) begin
               total++;
               if (o_x !== px || o_y !== py || o_pix_last !== pl) begin
                  bad++;
                  $display("FAIL stall_hold got (%0d,%0d,%b) exp (%0d,%0d,%b)",
                           o_x, o_y, o_pix_last, px, py, pl);
               end
            end
            px = o_x; py = o_y; pl = o_pix_last;
            if (pix_ready) begin
               idx++;
               last_hs = t;
               stalled = 0;
            end else begin
               stalled = 1;
            end
         end else begin
            total++;
            bad++;
            $display("FAIL valid_gap got valid=%b done=%b at cycle %0d exp pixel or done", o_pix_valid, o_tri_done, t);
         end
      end
      pix_ready = 1'b0;
      if (!finished) begin
         total++;
         bad++;
         $display("FAIL done_timeout got=none exp=tri_done within %0d cycles", limit);
      end else begin
         @(negedge clk);
         total++;
         if (o_tri_ready !== 1'b1 || o_busy !== 1'b0 || o_tri_done !== 1'b0) begin
            bad++;
            $display("FAIL return_idle got ready=%b busy=%b done=%b exp 1 0 0", o_tri_ready, o_busy, o_tri_done);
         end
`ifdef BBOX_PIXCOUNT_EN
         total++;
         if (o_pix_count !== 22'(n)) begin
            bad++;
            $display("FAIL pix_count_hold got=%0d exp=%0d", o_pix_count, n);
         end
`endif
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (ifa.tri_ready !== 1'b1 || ifa.pix_valid !== 1'b0 || ifa.pix_last !== 1'b0 ||
          ifa.pixel_x !== 11'd0 || ifa.pixel_y !== 11'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_big got ready=%b valid=%b last=%b x=%0d y=%0d busy=%b done=%b exp 1 0 0 0 0 0 0",
                  ifa.tri_ready, ifa.pix_valid, ifa.pix_last, ifa.pixel_x, ifa.pixel_y, busy_a, done_a);
      end
      total++;
      if (ifb.tri_ready !== 1'b1 || ifb.pix_valid !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
         bad++;
         $display("FAIL reset_small got ready=%b valid=%b busy=%b done=%b exp 1 0 0 0",
                  ifb.tri_ready, ifb.pix_valid, busy_b, done_b);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (ifa.tri_ready !== 1'b1 || ifa.pix_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset got ready=%b valid=%b exp 1 0", ifa.tri_ready, ifa.pix_valid);
      end
   endtask

   task automatic test_basic();
      run_tri(1'b0, 2, 3, 5, 1, 4, 4, 100, -1);
   endtask

   task automatic test_single_pixel();
      run_tri(1'b0, 7, 7, 7, 7, 7, 7, 100, -1);
   endtask

   task automatic test_empty();
      run_tri(1'b0, -10, -5, -3, -8, -1, -2, 100, -1);
      run_tri(1'b1, 20, 2, 30, 5, 17, 1, 100, -1);
   endtask

   task automatic test_clamp();
      run_tri(1'b1, -5, -5, 700, 3, 3, 500, 100, -1);
      run_tri(1'b0, -1000, 470, 1000, 479, 630, 1000, 100, -1);
   endtask

   task automatic test_stall();
      run_tri(1'b0, 2, 3, 5, 1, 4, 4, 50, -1);
      run_tri(1'b1, -5, -5, 700, 3, 3, 500, 50, -1);
   endtask

   task automatic test_reset_mid_scan();
      run_tri(1'b0, 2, 3, 5, 1, 4, 4, 100, 4);
   endtask

   task automatic test_back_to_back();
      run_tri(1'b1, 0, 0, 3, 0, 0, 2, 100, -1);
      run_tri(1'b1, 15, 7, 14, 6, 15, 6, 100, -1);
      run_tri(1'b0, 639, 479, 639, 479, 639, 479, 100, -1);
   endtask

   task automatic test_random();
      int bx, by;
      for (int i = 0; i < 16; i++) begin
         run_tri(1'b1,
                 int'($urandom_range(60)) - 20, int'($urandom_range(40)) - 16,
                 int'($urandom_range(60)) - 20, int'($urandom_range(40)) - 16,
                 int'($urandom_range(60)) - 20, int'($urandom_range(40)) - 16,
                 30 + int'($urandom_range(70)), -1);
      end
      for (int i = 0; i < 6; i++) begin
         bx = int'($urandom_range(680)) - 20;
         by = int'($urandom_range(520)) - 20;
         run_tri(1'b0,
                 bx + int'($urandom_range(12)) - 6, by + int'($urandom_range(12)) - 6,
                 bx + int'($urandom_range(12)) - 6, by + int'($urandom_range(12)) - 6,
                 bx + int'($urandom_range(12)) - 6, by + int'($urandom_range(12)) - 6,
                 40 + int'($urandom_range(60)), -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single_pixel();
      test_empty();
      test_clamp();
      test_stall();
      test_reset_mid_scan();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
